// File: rtl/mat_tile_reader_pkg.sv
// Shared types and constants for the matrix tile read sequencer.
package mat_tile_reader_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int MAX_MEM_LAT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/mat_tile_reader_if.sv
// Controller/memory/stream signal bundle of the tile reader; the reader uses the slave side.
interface mat_tile_reader_if;
  import mat_tile_reader_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] n_rows;
  logic [ADDR_W-1:0] n_cols;
  logic [ADDR_W-1:0] row_stride;
  logic              stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              last;
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_addr, n_rows, n_cols, row_stride, stall, mem_rd_data,
    output mem_addr, mem_rd_en, data_out, data_valid, last, busy, done
  );

  modport master (
    output start, base_addr, n_rows, n_cols, row_stride, stall, mem_rd_data,
    input  mem_addr, mem_rd_en, data_out, data_valid, last, busy, done
  );

endinterface

// File: rtl/mat_tile_reader_rd_valid_pipe.sv
// Valid/last tag pipeline that tracks each issued read until its data returns from memory.
module rd_valid_pipe
  import mat_tile_reader_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  // Out-of-range latencies are illegal; clamp so the structure still elaborates.
  localparam int DEPTH = (MEM_LAT < 1) ? 1 :
                         ((MEM_LAT > MAX_MEM_LAT) ? MAX_MEM_LAT : MEM_LAT);

  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] last_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {DEPTH{1'b0}};
      last_r  <= {DEPTH{1'b0}};
    end else begin
      valid_r[0] <= in_valid;
      last_r[0]  <= in_last;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        last_r[i]  <= last_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[DEPTH-1];
  assign out_last  = last_r[DEPTH-1];

endmodule

// File: rtl/mat_tile_reader.sv
// Walks a rectangular tile of data memory row by row, one read per unstalled cycle,
// and returns the words in order with valid/last flags.
module mat_tile_reader
  import mat_tile_reader_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  mat_tile_reader_if.slave bus
);

  state_t            state_r;
  state_t            state_nxt;
  logic [ADDR_W-1:0] n_rows_r;
  logic [ADDR_W-1:0] n_cols_r;
  logic [ADDR_W-1:0] stride_r;
  logic [ADDR_W-1:0] row_r;
  logic [ADDR_W-1:0] col_r;
  logic [ADDR_W-1:0] row_base_r;
  logic [DATA_W-1:0] data_out_r;
  logic              data_valid_r;
  logic              last_r;
  logic              start_s;
  logic              issue_s;
  logic              col_end_s;
  logic              row_end_s;
  logic              issue_last_s;
  logic              pipe_valid_s;
  logic              pipe_last_s;

  assign start_s      = (state_r == IDLE) && bus.start;
  assign issue_s      = (state_r == RUN) && !bus.stall;
  assign col_end_s    = (col_r == (n_cols_r - 16'd1));
  assign row_end_s    = (row_r == (n_rows_r - 16'd1));
  assign issue_last_s = issue_s && col_end_s && row_end_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if ((bus.n_rows == 16'd0) || (bus.n_cols == 16'd0)) begin
            state_nxt = FIN;
          end else begin
            state_nxt = RUN;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (issue_last_s) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = RUN;
        end
      end
      // The final word is visible on the outputs this cycle, so done follows next.
      DRAIN: begin
        if (data_valid_r && last_r) begin
          state_nxt = FIN;
        end else begin
          state_nxt = DRAIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tile parameters and row/column walk; row_base carries the running row start address.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_rows_r   <= 16'd0;
      n_cols_r   <= 16'd0;
      stride_r   <= 16'd0;
      row_r      <= 16'd0;
      col_r      <= 16'd0;
      row_base_r <= 16'd0;
    end else if (start_s) begin
      n_rows_r   <= bus.n_rows;
      n_cols_r   <= bus.n_cols;
      stride_r   <= bus.row_stride;
      row_r      <= 16'd0;
      col_r      <= 16'd0;
      row_base_r <= bus.base_addr;
    end else if (issue_s) begin
      if (col_end_s) begin
        col_r      <= 16'd0;
        row_base_r <= row_base_r + stride_r;
        row_r      <= row_r + 16'd1;
      end else begin
        col_r      <= col_r + 16'd1;
      end
    end
  end

  rd_valid_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_rd_valid_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (issue_s),
    .in_last   (issue_last_s),
    .out_valid (pipe_valid_s),
    .out_last  (pipe_last_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_r   <= 16'd0;
      data_valid_r <= 1'b0;
      last_r       <= 1'b0;
    end else begin
      data_valid_r <= pipe_valid_s;
      last_r       <= pipe_valid_s && pipe_last_s;
      if (pipe_valid_s) begin
        data_out_r <= bus.mem_rd_data;
      end
    end
  end

  assign bus.mem_rd_en  = issue_s;
  assign bus.mem_addr   = issue_s ? (row_base_r + col_r) : 16'd0;
  assign bus.data_out   = data_out_r;
  assign bus.data_valid = data_valid_r;
  assign bus.last       = last_r;
  assign bus.busy       = (state_r != IDLE);
  assign bus.done       = (state_r == FIN);

endmodule

// File: tb/tb_mat_tile_reader.sv
// Self-checking bench: two readers (latency 1 and 2) driven identically and compared
// cycle by cycle against a tile-level reference model.
module tb_mat_tile_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stall;
  logic [15:0] base_addr;
  logic [15:0] n_rows;
  logic [15:0] n_cols;
  logic [15:0] row_stride;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] p1;
  logic [15:0] p2 [2];

  logic        e_en   [2][64];
  logic [15:0] e_addr [2][64];
  logic        e_dv   [2][64];
  logic [15:0] e_data [2][64];
  logic        e_last [2][64];
  logic        e_busy [2][64];
  logic        e_done [2][64];

  mat_tile_reader_if ifc1 ();
  mat_tile_reader_if ifc2 ();

  mat_tile_reader #(.MEM_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(ifc1.slave));
  mat_tile_reader #(.MEM_LAT(2)) u_dut2 (.clk(clk), .reset(reset), .bus(ifc2.slave));

  always #5 clk = ~clk;

  assign ifc1.start = start;          assign ifc2.start = start;
  assign ifc1.stall = stall;          assign ifc2.stall = stall;
  assign ifc1.base_addr = base_addr;  assign ifc2.base_addr = base_addr;
  assign ifc1.n_rows = n_rows;        assign ifc2.n_rows = n_rows;
  assign ifc1.n_cols = n_cols;        assign ifc2.n_cols = n_cols;
  assign ifc1.row_stride = row_stride; assign ifc2.row_stride = row_stride;
  assign ifc1.mem_rd_data = p1;
  assign ifc2.mem_rd_data = p2[1];

  // Synchronous memories; non-read cycles return junk so stray captures show up.
  always @(posedge clk) begin
    p1    <= ifc1.mem_rd_en ? mem[ifc1.mem_addr] : 16'($urandom);
    p2[0] <= ifc2.mem_rd_en ? mem[ifc2.mem_addr] : 16'($urandom);
    p2[1] <= p2[0];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached after %0d assertions", n_assert);
    $fatal(1, "time limit");
  end

  function automatic string tg(input string n, input int li, input int cyc);
    return $sformatf("%s L%0d c%0d", n, li + 1, cyc);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int li = 0; li < 2; li++) begin
      for (int cc = 0; cc < 64; cc++) begin
        e_en[li][cc] = 1'b0;   e_addr[li][cc] = 16'd0;
        e_dv[li][cc] = 1'b0;   e_data[li][cc] = 16'd0;
        e_last[li][cc] = 1'b0; e_busy[li][cc] = 1'b0; e_done[li][cc] = 1'b0;
      end
    end
  endtask

  // Reference: enumerate tile addresses, place issues on unstalled cycles, shift by latency.
  task automatic build_model(input logic [15:0] b, input logic [15:0] r, input logic [15:0] c,
                             input logic [15:0] s, input logic [63:0] m, output int end_cyc);
    logic [15:0] addrs [$];
    int          issue [$];
    int          total, k, nl, lat;
    clear_model();
    addrs = {};
    issue = {};
    total = int'(r) * int'(c);
    for (int i = 0; i < int'(r); i++)
      for (int j = 0; j < int'(c); j++)
        addrs.push_back(16'(int'(b) + i * int'(s) + j));
    if (total == 0) begin
      for (int li = 0; li < 2; li++) begin
        e_busy[li][1] = 1'b1;
        e_done[li][1] = 1'b1;
      end
      end_cyc = 1;
    end else begin
      k = 1;
      while (issue.size() < total) begin
        if (!m[k]) issue.push_back(k);
        k++;
      end
      nl = issue[total-1];
      for (int li = 0; li < 2; li++) begin
        lat = li + 1;
        for (int n = 0; n < total; n++) begin
          e_en[li][issue[n]]         = 1'b1;
          e_addr[li][issue[n]]       = addrs[n];
          e_dv[li][issue[n]+lat+1]   = 1'b1;
          e_data[li][issue[n]+lat+1] = mem[addrs[n]];
        end
        e_last[li][nl+lat+1] = 1'b1;
        e_done[li][nl+lat+2] = 1'b1;
        for (int cc = 1; cc <= nl + lat + 2; cc++) e_busy[li][cc] = 1'b1;
      end
      end_cyc = nl + 4;
    end
  endtask

  task automatic check_cycle(input int cyc, input bit zero);
    for (int li = 0; li < 2; li++) begin
      logic        en, dv, lst, bsy, dn;
      logic [15:0] ad, dq;
      if (li == 0) begin
        en = ifc1.mem_rd_en; ad = ifc1.mem_addr; dv = ifc1.data_valid; dq = ifc1.data_out;
        lst = ifc1.last; bsy = ifc1.busy; dn = ifc1.done;
      end else begin
        en = ifc2.mem_rd_en; ad = ifc2.mem_addr; dv = ifc2.data_valid; dq = ifc2.data_out;
        lst = ifc2.last; bsy = ifc2.busy; dn = ifc2.done;
      end
      chk1(tg("rd_en", li, cyc), en, e_en[li][cyc]);
      if (e_en[li][cyc] || zero) chk16(tg("addr", li, cyc), ad, e_addr[li][cyc]);
      chk1(tg("valid", li, cyc), dv, e_dv[li][cyc]);
      if (e_dv[li][cyc] || zero) chk16(tg("data", li, cyc), dq, e_data[li][cyc]);
      chk1(tg("last", li, cyc), lst, e_last[li][cyc]);
      chk1(tg("busy", li, cyc), bsy, e_busy[li][cyc]);
      chk1(tg("done", li, cyc), dn, e_done[li][cyc]);
    end
  endtask

  // Cycle 0 carries start; cycles 1..end are checked mid-cycle against the model.
  task automatic run_tile(input logic [15:0] b, input logic [15:0] r, input logic [15:0] c,
                          input logic [15:0] s, input logic [63:0] m,
                          input bit busy_start, input int rst_cyc);
    int end_cyc;
    build_model(b, r, c, s, m, end_cyc);
    if (rst_cyc > 0) begin
      for (int li = 0; li < 2; li++) begin
        for (int cc = rst_cyc + 1; cc < 64; cc++) begin
          e_en[li][cc] = 1'b0;   e_addr[li][cc] = 16'd0;
          e_dv[li][cc] = 1'b0;   e_data[li][cc] = 16'd0;
          e_last[li][cc] = 1'b0; e_busy[li][cc] = 1'b0; e_done[li][cc] = 1'b0;
        end
      end
      end_cyc = rst_cyc + 6;
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; n_rows = r; n_cols = c; row_stride = s;
    stall = 1'b0; reset = 1'b0;
    @(negedge clk);
    check_cycle(0, 1'b0);
    for (int cyc = 1; cyc <= end_cyc; cyc++) begin
      @(posedge clk); #1;
      start = busy_start && (cyc == 2);
      if (start) begin
        base_addr  = b + 16'h1234;
        n_rows     = r + 16'd1;
        n_cols     = c + 16'd2;
        row_stride = s + 16'd7;
      end
      reset = (cyc == rst_cyc);
      stall = m[cyc];
      @(negedge clk);
      check_cycle(cyc, (rst_cyc > 0) && (cyc > rst_cyc));
    end
  endtask

  initial begin
    logic [63:0] m;
    logic [15:0] rr, cc;
    bit          bs;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    base_addr = 16'd0; n_rows = 16'd0; n_cols = 16'd0; row_stride = 16'd0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cycle(0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;

    m = 64'd0;
    run_tile(16'h0100, 16'd2, 16'd3, 16'h0010, m, 1'b0, 0);
    run_tile(16'h0040, 16'd0, 16'd5, 16'h0008, m, 1'b0, 0);
    m[2] = 1'b1; m[3] = 1'b1;
    run_tile(16'h3000, 16'd1, 16'd4, 16'h0100, m, 1'b0, 0);
    m = 64'd0;
    run_tile(16'hFFFE, 16'd1, 16'd3, 16'h0020, m, 1'b0, 0);
    run_tile(16'h0200, 16'd2, 16'd2, 16'h0040, m, 1'b0, 3);
    run_tile(16'h0200, 16'd2, 16'd2, 16'h0040, m, 1'b0, 0);
    run_tile(16'h0500, 16'd2, 16'd2, 16'h0010, m, 1'b1, 0);
    run_tile(16'h0700, 16'd3, 16'd0, 16'h0010, m, 1'b0, 0);

    for (int t = 0; t < 25; t++) begin
      m = 64'd0;
      for (int i = 1; i <= 30; i++) if ($urandom_range(0, 2) == 0) m[i] = 1'b1;
      rr = 16'($urandom_range(0, 3));
      cc = 16'($urandom_range(0, 4));
      bs = (rr != 16'd0) && (cc != 16'd0) && ($urandom_range(0, 3) == 0);
      run_tile(16'($urandom), rr, cc, 16'($urandom), m, bs, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_tile_reader.md
# mat_tile_reader

Streaming read sequencer for the matrix-multiply datapath. It is the consumer-side counterpart of the load/increment address registers. Started with a base address, row count, column count and row stride, it walks a rectangular tile of data memory row by row, issues one synchronous read per cycle and returns the words in order with valid/last flags. It sits between the controller, which starts it, and the core's operand registers, which consume the stream.

## Interface
- `MEM_LAT`, default 1: data-memory read latency in cycles, from `mem_rd_en` to `mem_rd_data`. Legal range is 1–4.
- `clk` in 1: the single clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a tile. Sampled in IDLE only.
- `base_addr` in 16: address of element (0,0). Latched at start.
- `n_rows` in 16: number of rows. Latched at start.
- `n_cols` in 16: number of columns. Latched at start.
- `row_stride` in 16: address distance between consecutive rows. Latched at start.
- `stall` in 1: suppresses issue of a new read in the current cycle.
- `mem_addr` out 16: read address to data memory.
- `mem_rd_en` out 1: read strobe.
- `mem_rd_data` in 16: memory read data, valid `MEM_LAT` cycles after the strobe.
- `data_out` out 16: registered returned word.
- `data_valid` out 1: `data_out` holds a word this cycle.
- `last` out 1: high with the final word of the tile.
- `busy` out 1: a tile is in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- The state machine has four states: IDLE, RUN, DRAIN and FIN.
- **IDLE.** When `start` is high, latch all four parameters and clear `row`, `col` and `row_base` (`row_base` is loaded with `base_addr`).
  - If `n_rows` or `n_cols` is 0, go to FIN.
  - Otherwise go to RUN.
- **RUN.** Each cycle with `stall` low:
  - Assert `mem_rd_en` with `mem_addr = row_base + col`.
  - Advance `col`. When `col == n_cols-1`:
    - set `col` to 0;
    - set `row_base` to `row_base + row_stride`;
    - increment `row`.
  - Issuing the element at `row == n_rows-1` and `col == n_cols-1` moves the block to DRAIN.
  - When `stall` is high, `mem_rd_en` is 0 and the counters hold.
- **DRAIN.** Wait until the last issued read has returned and been presented as `data_valid` with `last`, then go to FIN.
- **FIN.** Assert `done` for one cycle, then go to IDLE.
- **Return path.** A `MEM_LAT`-deep valid/last shift register follows every issued read.
  - When a tagged read arrives, register `mem_rd_data` into `data_out` and set `data_valid`.
  - `last` rides with the final read.
- **Stall.** `stall` gates issue only. Reads already in flight (at most `MEM_LAT`) are still delivered, and the downstream consumer must accept them.
- **Arithmetic.** All address arithmetic is 16-bit unsigned, modulo 2^16. Wrap past 0xFFFF is silent.
- **Start while busy.** `start` outside IDLE is ignored. Parameter inputs are not re-sampled.
- **Reset mid-tile.** `reset` at any time forces IDLE and zeroes the counters and the valid pipe. In-flight data is discarded, and no `done` is produced for the aborted tile.

## Timing
- **Reset values.** On reset, all of the following are 0: `mem_addr`, `mem_rd_en`, `data_out`, `data_valid`, `last`, `busy` and `done`.
- `start` is sampled at edge 0.
- The first `mem_rd_en` occurs in cycle 1.
- `busy` is high from cycle 1 through the cycle in which `done` is high, inclusive.
- For a read issued in cycle k, `data_valid` is high in cycle k+`MEM_LAT`+1.
- With the final read issued in cycle N:
  - `last` and `data_valid` are high in cycle N+`MEM_LAT`+1;
  - `done` is high in cycle N+`MEM_LAT`+2.
- Without stall, an R×C tile issues in exactly R·C consecutive cycles.
- Empty tile (`n_rows` or `n_cols` is 0): `done` is high in cycle 1 and `mem_rd_en` never asserts. `busy` is high only in cycle 1.
- A new `start` is accepted in the cycle after `done`.

## Structure
- The shared package holds:
  - the state enum (IDLE, RUN, DRAIN, FIN);
  - the 16-bit address and data width constants;
  - the `MEM_LAT` upper bound.
- The return path is one sub-module, `rd_valid_pipe`: a parameterised `MEM_LAT`-stage shift register carrying valid and last, with synchronous `reset`.
- The counters (`row`, `col`, `row_base`) stay inline in the top module.

## Test plan
- **2×3 tile.** `MEM_LAT`=1, `base_addr`=0x0100, `row_stride`=0x0010, no stall.
  - Required: `mem_addr` is 0x0100, 0x0101, 0x0102, 0x0110, 0x0111, 0x0112 in cycles 1–6.
  - Required: six `data_valid` words in cycles 3–8 matching memory contents, `last` in cycle 8 only, `done` in cycle 9.
- **Empty tile.** `n_rows`=0, `n_cols`=5.
  - Required: `done` in cycle 1, `mem_rd_en` never high, `data_valid` never high.
- **Stall.** 1×4 tile with `stall` high in cycles 2–3.
  - Required: addresses base+0 in cycle 1, base+1 in cycle 4, base+2 in cycle 5, base+3 in cycle 6.
  - Required: word order preserved and `last` on the fourth word only.
- **Address wrap.** `base_addr`=0xFFFE, 1×3 tile.
  - Required: addresses 0xFFFE, 0xFFFF, 0x0000.
- **Reset mid-tile.** `reset` in cycle 3 of a 2×2 tile with `MEM_LAT`=2.
  - Required: all outputs 0 from cycle 4 and no `done` for that tile.
  - Required: a fresh `start` afterwards completes normally.
- **Start while busy.** Pulse `start` with different parameters in cycle 2 of a running 2×2 tile.
  - Required: it is ignored, and the original four addresses are issued unchanged.
